overlay_timing_gen: RTL and testbench

OVERLAY_TIMING_GEN -- requirements
Module: overlay_timing_gen

---
 rtl/overlay_timing_gen_pkg.sv | 41 ++++
 rtl/overlay_timing_gen_counter.sv | 45 ++++
 rtl/overlay_timing_gen.sv | 192 +++++++++++++++++++
 tb/tb_overlay_timing_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_timing_gen_pkg.sv
// Shared timing defaults and region classification for the overlay timing generator.
package overlay_timing_gen_pkg;

    localparam int H_ACTIVE_DEF = 1920;
    localparam int H_FP_DEF     = 88;
    localparam int H_SYNC_DEF   = 44;
    localparam int H_BP_DEF     = 148;
    localparam int V_ACTIVE_DEF = 1080;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 36;
    localparam int CNT_W_DEF    = 12;
    localparam int DATA_W_DEF   = 24;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        RGN_ACTIVE,
        RGN_FP,
        RGN_SYNC,
        RGN_BP
    } region_e;

    // Regions are laid out in the order active, front porch, sync, back porch.
    function automatic region_e region_of(input int cnt, input int active,
                                          input int fp, input int sync);
        region_e rgn;
        if (cnt < active) begin
            rgn = RGN_ACTIVE;
        end else if (cnt < active + fp) begin
            rgn = RGN_FP;
        end else if (cnt < active + fp + sync) begin
            rgn = RGN_SYNC;
        end else begin
            rgn = RGN_BP;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/overlay_timing_gen_counter.sv
// Wrapping up-counter 0..TOP with clear, increment and parallel load.
module overlay_timing_gen_counter
    import overlay_timing_gen_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF,
    parameter int TOP   = H_TOTAL_DEF - 1
) (
    input  logic             clock,
    input  logic             masterReset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign wrap_o  = inc_i && (count_q == WIDTH'(TOP));
    assign count_o = count_q;

    // Next count: clear wins over load, load wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!masterReset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/overlay_timing_gen.sv
// Video timing generator with a single rectangular overlay window fed by a
// valid/ready pixel stream; everything outside the window shows bgColour.
module overlay_timing_gen
    import overlay_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              masterReset_n,
    input  logic              enable,
    input  logic              ovlEnable,
    input  logic [CNT_W-1:0]  ovlX,
    input  logic [CNT_W-1:0]  ovlY,
    input  logic [CNT_W-1:0]  ovlW,
    input  logic [CNT_W-1:0]  ovlH,
    input  logic [DATA_W-1:0] bgColour,
    input  logic [DATA_W-1:0] pixData,
    input  logic              pixValid,
    output logic              pixReady,
    output logic              DE,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic [DATA_W-1:0] data,
    output logic              frameStart,
    output logic              underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             unused_v_wrap;

    overlay_timing_gen_counter #(
        .WIDTH (CNT_W),
        .TOP   (H_TOTAL - 1)
    ) u_h_cnt (
        .clock         (clock),
        .masterReset_n (masterReset_n),
        .clr_i         (~enable),
        .inc_i         (1'b1),
        .load_i        (1'b0),
        .load_val_i    ('0),
        .count_o       (h_cnt),
        .wrap_o        (h_wrap)
    );

    overlay_timing_gen_counter #(
        .WIDTH (CNT_W),
        .TOP   (V_TOTAL - 1)
    ) u_v_cnt (
        .clock         (clock),
        .masterReset_n (masterReset_n),
        .clr_i         (~enable),
        .inc_i         (h_wrap),
        .load_i        (1'b0),
        .load_val_i    ('0),
        .count_o       (v_cnt),
        .wrap_o        (unused_v_wrap)
    );

    region_e h_rgn;
    region_e v_rgn;
    logic    at_origin;
    logic    active;

    assign h_rgn     = region_of(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
    assign v_rgn     = region_of(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active    = (h_rgn == RGN_ACTIVE) && (v_rgn == RGN_ACTIVE);

    logic             shd_en_q, shd_en_d;
    logic [CNT_W-1:0] shd_x_q, shd_x_d;
    logic [CNT_W-1:0] shd_y_q, shd_y_d;
    logic [CNT_W-1:0] shd_w_q, shd_w_d;
    logic [CNT_W-1:0] shd_h_q, shd_h_d;

    // Window settings are frozen for the whole frame, sampled at the origin.
    always_comb begin
        shd_en_d = shd_en_q;
        shd_x_d  = shd_x_q;
        shd_y_d  = shd_y_q;
        shd_w_d  = shd_w_q;
        shd_h_d  = shd_h_q;
        if (at_origin) begin
            shd_en_d = ovlEnable;
            shd_x_d  = ovlX;
            shd_y_d  = ovlY;
            shd_w_d  = ovlW;
            shd_h_d  = ovlH;
        end
    end

    // Shadow register bank.
    always_ff @(posedge clock) begin
        if (!masterReset_n) begin
            shd_en_q <= 1'b0;
            shd_x_q  <= '0;
            shd_y_q  <= '0;
            shd_w_q  <= '0;
            shd_h_q  <= '0;
        end else begin
            shd_en_q <= shd_en_d;
            shd_x_q  <= shd_x_d;
            shd_y_q  <= shd_y_d;
            shd_w_q  <= shd_w_d;
            shd_h_q  <= shd_h_d;
        end
    end

    // The origin pixel is evaluated while the shadows are being loaded, so it
    // looks at the live inputs that are about to become this frame's settings.
    logic             win_en;
    logic [CNT_W-1:0] win_x, win_y, win_w, win_h;
    logic [CNT_W:0]   x_end, y_end;
    logic             in_x, in_y, in_win;

    assign win_en = at_origin ? ovlEnable : shd_en_q;
    assign win_x  = at_origin ? ovlX      : shd_x_q;
    assign win_y  = at_origin ? ovlY      : shd_y_q;
    assign win_w  = at_origin ? ovlW      : shd_w_q;
    assign win_h  = at_origin ? ovlH      : shd_h_q;

    // One extra bit keeps the far edge from wrapping back into range.
    assign x_end  = {1'b0, win_x} + {1'b0, win_w};
    assign y_end  = {1'b0, win_y} + {1'b0, win_h};
    assign in_x   = (h_cnt >= win_x) && ({1'b0, h_cnt} < x_end);
    assign in_y   = (v_cnt >= win_y) && ({1'b0, v_cnt} < y_end);
    assign in_win = win_en && in_x && in_y && active;

    assign pixReady = masterReset_n && enable && in_win;

    logic              de_q, de_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              fs_q, fs_d;
    logic              uf_q, uf_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Output values for the current counter state; all idle while disabled.
    always_comb begin
        de_d   = enable && active;
        hs_d   = (enable && (h_rgn == RGN_SYNC)) ? HS_POL : ~HS_POL;
        vs_d   = (enable && (v_rgn == RGN_SYNC)) ? VS_POL : ~VS_POL;
        fs_d   = enable && at_origin;
        uf_d   = pixReady && !pixValid;
        data_d = '0;
        if (de_d) begin
            data_d = (pixReady && pixValid) ? pixData : bgColour;
        end
    end

    // Output registers, one cycle behind the counters.
    always_ff @(posedge clock) begin
        if (!masterReset_n) begin
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
            data_q <= '0;
        end else begin
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
            data_q <= data_d;
        end
    end

    assign DE         = de_q;
    assign HSYNC      = hs_q;
    assign VSYNC      = vs_q;
    assign frameStart = fs_q;
    assign underflow  = uf_q;
    assign data       = data_q;

endmodule

// File: tb/tb_overlay_timing_gen.sv
// Directed bench for overlay_timing_gen on a 14x7 raster.
module tb_overlay_timing_gen;

    localparam int CW    = 12;
    localparam int DW    = 24;
    localparam int FRAME = 98;
    localparam logic [DW-1:0] BG = 24'hABCDEF;

    logic          clock = 1'b0;
    logic          masterReset_n;
    logic          enable;
    logic          ovlEnable;
    logic [CW-1:0] ovlX, ovlY, ovlW, ovlH;
    logic [DW-1:0] bgColour, pixData;
    logic          pixValid;
    logic          pixReady, DE, HSYNC, VSYNC, frameStart, underflow;
    logic [DW-1:0] data;

    always #5 clock = ~clock;

    overlay_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b0),
        .CNT_W    (CW), .DATA_W (DW)
    ) dut (
        .clock         (clock),
        .masterReset_n (masterReset_n),
        .enable        (enable),
        .ovlEnable     (ovlEnable),
        .ovlX          (ovlX),
        .ovlY          (ovlY),
        .ovlW          (ovlW),
        .ovlH          (ovlH),
        .bgColour      (bgColour),
        .pixData       (pixData),
        .pixValid      (pixValid),
        .pixReady      (pixReady),
        .DE            (DE),
        .HSYNC         (HSYNC),
        .VSYNC         (VSYNC),
        .data          (data),
        .frameStart    (frameStart),
        .underflow     (underflow)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] obs_data [FRAME];
    logic          obs_de   [FRAME];
    logic          obs_hs   [FRAME];
    logic          obs_vs   [FRAME];
    logic          obs_fs   [FRAME];
    logic          obs_uf   [FRAME];
    int de_cnt, hs_cnt, vs_low_cnt, fs_cnt, uf_cnt, ready_cnt, cons_cnt;
    int act_bad, idle_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold counters at the origin, then run: on return sample k=0 shows pixel (0,0).
    task automatic restart();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        tick();
    endtask

    // Records one frame of outputs; sample k shows pixel k while pixReady
    // reflects pixel k+1. stall_pos drops pixValid for that pixel.
    task automatic capture_frame(input int stall_pos, input int chg_k, input logic [CW-1:0] chg_x);
        logic cons;
        de_cnt = 0; hs_cnt = 0; vs_low_cnt = 0; fs_cnt = 0; uf_cnt = 0;
        ready_cnt = 0; cons_cnt = 0; act_bad = 0; idle_bad = 0;
        for (int k = 0; k < FRAME; k++) begin
            obs_data[k] = data;
            obs_de[k]   = DE;
            obs_hs[k]   = HSYNC;
            obs_vs[k]   = VSYNC;
            obs_fs[k]   = frameStart;
            obs_uf[k]   = underflow;
            de_cnt     += int'(DE);
            hs_cnt     += int'(HSYNC);
            vs_low_cnt += int'(!VSYNC);
            fs_cnt     += int'(frameStart);
            uf_cnt     += int'(underflow);
            if (DE && data !== BG) act_bad++;
            if (!DE && data !== '0) idle_bad++;
            if (k == chg_k) ovlX = chg_x;
            pixValid = (k + 1 != stall_pos);
            #1;
            cons = pixReady && pixValid;
            if (pixReady) ready_cnt++;
            if (cons) cons_cnt++;
            tick();
            if (cons) pixData = pixData + 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_de"}, DE, 1'b0);
        chk({tag, "_hs"}, HSYNC, 1'b0);
        chk({tag, "_vs"}, VSYNC, 1'b1);
        chk({tag, "_data"}, data, '0);
        chk({tag, "_fs"}, frameStart, 1'b0);
        chk({tag, "_uf"}, underflow, 1'b0);
        chk({tag, "_ready"}, pixReady, 1'b0);
    endtask

    initial begin
        masterReset_n = 1'b0;
        enable        = 1'b1;
        ovlEnable     = 1'b0;
        ovlX = '0; ovlY = '0; ovlW = '0; ovlH = '0;
        bgColour      = BG;
        pixData       = 24'd1;
        pixValid      = 1'b1;

        // Reset state, with enable already high
        tick(); tick(); tick();
        check_idle("reset");

        // Free run from reset release, no overlay
        masterReset_n = 1'b1;
        tick();
        capture_frame(-1, -1, '0);
        chk("fr_fs0", obs_fs[0], 1'b1);
        chk("fr_fs1", obs_fs[1], 1'b0);
        chk("fr_data0", obs_data[0], BG);
        chk("fr_de7", obs_de[7], 1'b1);
        chk("fr_de8", obs_de[8], 1'b0);
        chk("fr_data8", obs_data[8], 24'h0);
        chk("fr_hs9", obs_hs[9], 1'b0);
        chk("fr_hs10", obs_hs[10], 1'b1);
        chk("fr_hs11", obs_hs[11], 1'b1);
        chk("fr_hs12", obs_hs[12], 1'b0);
        chk("fr_vs69", obs_vs[69], 1'b1);
        chk("fr_vs70", obs_vs[70], 1'b0);
        chk("fr_vs84", obs_vs[84], 1'b1);
        chk("fr_de56", obs_de[56], 1'b0);
        chk("fr_de_cnt", de_cnt, 32);
        chk("fr_hs_cnt", hs_cnt, 14);
        chk("fr_vs_cnt", vs_low_cnt, 14);
        chk("fr_fs_cnt", fs_cnt, 1);
        chk("fr_act_bad", act_bad, 0);
        chk("fr_idle_bad", idle_bad, 0);
        capture_frame(-1, -1, '0);
        chk("fr2_fs0", obs_fs[0], 1'b1);
        chk("fr2_fs_cnt", fs_cnt, 1);
        chk("fr2_de_cnt", de_cnt, 32);

        // Window 2,1 size 3x2 with a continuous stream
        ovlEnable = 1'b1; ovlX = 12'd2; ovlY = 12'd1; ovlW = 12'd3; ovlH = 12'd2;
        pixData = 24'd1;
        restart();
        capture_frame(-1, -1, '0);
        chk("win_p21", obs_data[16], 24'd1);
        chk("win_p41", obs_data[18], 24'd3);
        chk("win_p22", obs_data[30], 24'd4);
        chk("win_p42", obs_data[32], 24'd6);
        chk("win_p11", obs_data[15], BG);
        chk("win_p51", obs_data[19], BG);
        chk("win_p20", obs_data[2], BG);
        chk("win_p23", obs_data[44], BG);
        chk("win_ready", ready_cnt, 6);
        chk("win_uf", uf_cnt, 0);

        // Stall on pixel (3,1)
        pixData = 24'd1;
        restart();
        capture_frame(17, -1, '0);
        chk("stl_p21", obs_data[16], 24'd1);
        chk("stl_p31", obs_data[17], BG);
        chk("stl_uf31", obs_uf[17], 1'b1);
        chk("stl_p41", obs_data[18], 24'd2);
        chk("stl_p22", obs_data[30], 24'd3);
        chk("stl_p42", obs_data[32], 24'd5);
        chk("stl_uf_cnt", uf_cnt, 1);
        chk("stl_ready", ready_cnt, 6);
        chk("stl_cons", cons_cnt, 5);

        // Window 6,3 size 5x5 clipped to 2x1
        ovlX = 12'd6; ovlY = 12'd3; ovlW = 12'd5; ovlH = 12'd5;
        pixData = 24'd1;
        restart();
        capture_frame(-1, -1, '0);
        chk("clp_p53", obs_data[47], BG);
        chk("clp_p63", obs_data[48], 24'd1);
        chk("clp_p73", obs_data[49], 24'd2);
        chk("clp_de83", obs_de[50], 1'b0);
        chk("clp_p83", obs_data[50], 24'h0);
        chk("clp_p64", obs_data[62], 24'h0);
        chk("clp_ready", ready_cnt, 2);
        chk("clp_cons", cons_cnt, 2);

        // ovlX changed mid-frame takes effect on the following frame
        ovlX = 12'd2; ovlY = 12'd1; ovlW = 12'd3; ovlH = 12'd2;
        pixData = 24'd1;
        restart();
        capture_frame(-1, 15, 12'd5);
        chk("mid_a_p21", obs_data[16], 24'd1);
        chk("mid_a_p51", obs_data[19], BG);
        chk("mid_a_p22", obs_data[30], 24'd4);
        chk("mid_a_ready", ready_cnt, 6);
        capture_frame(-1, -1, '0);
        chk("mid_b_p21", obs_data[16], BG);
        chk("mid_b_p51", obs_data[19], 24'd7);
        chk("mid_b_p72", obs_data[35], 24'd12);
        chk("mid_b_ready", ready_cnt, 6);

        // Zero width gives an empty window
        ovlX = 12'd2; ovlW = 12'd0;
        restart();
        capture_frame(-1, -1, '0);
        chk("w0_ready", ready_cnt, 0);
        chk("w0_p21", obs_data[16], BG);
        chk("w0_uf", uf_cnt, 0);

        // Reset asserted mid-line
        ovlW = 12'd3;
        pixValid = 1'b1;
        restart();
        for (int i = 0; i < 16; i++) tick();
        chk("rst_pre_ready", pixReady, 1'b1);
        chk("rst_pre_de", DE, 1'b1);
        masterReset_n = 1'b0;
        tick();
        check_idle("rst_mid");
        tick();
        masterReset_n = 1'b1;
        #1;
        chk("rst_rel_fs_pre", frameStart, 1'b0);
        tick();
        chk("rst_rel_fs", frameStart, 1'b1);
        chk("rst_rel_de", DE, 1'b1);
        chk("rst_rel_data", data, BG);

        // enable dropped mid-line
        for (int i = 0; i < 16; i++) tick();
        chk("en_pre_ready", pixReady, 1'b1);
        enable = 1'b0;
        tick();
        check_idle("en_off");
        tick();
        chk("en_off2_fs", frameStart, 1'b0);
        enable = 1'b1;
        tick();
        chk("en_on_fs", frameStart, 1'b1);
        chk("en_on_de", DE, 1'b1);
        chk("en_on_data", data, BG);
        tick();
        chk("en_on_fs_once", frameStart, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
